// File: rtl/fp_mul_sequencer.sv
// Sequences one FP multiply: captures a request, feeds A then B to the multiplier core,
// collects the product and presents it to the register-file writeback port with sticky flags.
module fp_mul_sequencer #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [4:0]  req_rd,
  output logic [31:0] mul_a,
  output logic        mul_a_stb,
  input  logic        mul_a_ack,
  output logic [31:0] mul_b,
  output logic        mul_b_stb,
  input  logic        mul_b_ack,
  input  logic [31:0] mul_z,
  input  logic        mul_z_stb,
  output logic        mul_z_ack,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic [4:0]  fflags,
  input  logic        fflags_clr,
  output logic        err_timeout
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SEND_A = 3'd1;
  localparam logic [2:0] S_SEND_B = 3'd2;
  localparam logic [2:0] S_WAIT_Z = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       rd_q;
  logic [4:0]       new_flags;
  logic             cap;

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // Handshake outputs are pure state decodes, so no input reaches an output combinationally.
  assign req_ready = (state == S_IDLE);
  assign mul_a_stb = (state == S_SEND_A);
  assign mul_b_stb = (state == S_SEND_B);
  assign mul_z_ack = (state == S_WAIT_Z);
  assign wb_valid  = (state == S_WB);

  assign cap = (state == S_WAIT_Z) && mul_z_stb;

  always_comb begin
    new_flags    = 5'd0;
    new_flags[4] = is_nan(mul_z) && !is_nan(mul_a) && !is_nan(mul_b);
    new_flags[2] = (mul_z[30:23] == 8'hFF) && (mul_z[22:0] == 23'd0) &&
                   (mul_a[30:23] != 8'hFF) && (mul_b[30:23] != 8'hFF);
    new_flags[1] = (mul_z[30:23] == 8'h00) && (mul_z[22:0] != 23'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      rd_q        <= '0;
      mul_a       <= '0;
      mul_b       <= '0;
      wb_rd       <= '0;
      wb_data     <= '0;
      fflags      <= '0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          mul_a <= req_a;
          mul_b <= req_b;
          rd_q  <= req_rd;
          state <= S_SEND_A;
        end
        S_SEND_A: if (mul_a_ack) state <= S_SEND_B;
        S_SEND_B: if (mul_b_ack) begin
          cnt   <= '0;
          state <= S_WAIT_Z;
        end
        // A product arriving on the last watchdog cycle still wins.
        S_WAIT_Z: if (mul_z_stb) begin
          wb_data <= mul_z;
          wb_rd   <= rd_q;
          state   <= S_WB;
        end else if (cnt == CNT_LAST) begin
          err_timeout <= 1'b1;
          state       <= S_HALT;
        end else begin
          cnt <= cnt + 1'b1;
        end
        S_WB:    if (wb_ready) state <= S_IDLE;
        S_HALT:  state <= S_HALT;
        default: state <= S_IDLE;
      endcase

      if (cap)             fflags <= (fflags_clr ? 5'd0 : fflags) | new_flags;
      else if (fflags_clr) fflags <= 5'd0;
    end
  end

endmodule

// File: tb/tb_fp_mul_sequencer.sv
// Directed bench for fp_mul_sequencer: the bench plays the issue logic, multiplier core and
// register file, and a transaction-level model predicts every writeback and the sticky flags.
module tb_fp_mul_sequencer;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [31:0] req_a, req_b;
  logic [4:0]  req_rd;
  logic [31:0] mul_a, mul_b, mul_z;
  logic        mul_a_stb, mul_a_ack, mul_b_stb, mul_b_ack, mul_z_stb, mul_z_ack;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [4:0]  fflags;
  logic        fflags_clr, err_timeout;

  fp_mul_sequencer #(.TIMEOUT_CYCLES(T), .CNT_W(5)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
    .mul_a(mul_a), .mul_a_stb(mul_a_stb), .mul_a_ack(mul_a_ack),
    .mul_b(mul_b), .mul_b_stb(mul_b_stb), .mul_b_ack(mul_b_ack),
    .mul_z(mul_z), .mul_z_stb(mul_z_stb), .mul_z_ack(mul_z_ack),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .fflags(fflags), .fflags_clr(fflags_clr), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [4:0]  fl;
  } wb_t;

  wb_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          wb_seen = 0;
  logic [4:0]  mflags = 5'd0;
  logic [31:0] exp_a = 32'd0;
  logic [31:0] exp_b = 32'd0;
  logic        exp_err = 1'b0;
  logic        exp_halt = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // IEEE-754 exception classification of one multiply, straight from the flag rules.
  function automatic logic [4:0] model_flags(input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] z);
    logic [7:0] ea, eb, ez;
    logic       na, nb, nz, nv, of_, uf;
    ea = a[30:23]; eb = b[30:23]; ez = z[30:23];
    na = (ea == 8'd255) && (a[22:0] != 0);
    nb = (eb == 8'd255) && (b[22:0] != 0);
    nz = (ez == 8'd255) && (z[22:0] != 0);
    nv  = nz && !na && !nb;
    of_ = (ez == 8'd255) && (z[22:0] == 0) && (ea != 8'd255) && (eb != 8'd255);
    uf  = (ez == 8'd0) && (z[22:0] != 0);
    return {nv, 1'b0, of_, uf, 1'b0};
  endfunction

  // Per-cycle compare against the model, sampled mid-low-phase.
  always @(negedge clk) begin
    #1;
    if (!reset) begin
      int n;
      n = int'(req_ready) + int'(mul_a_stb) + int'(mul_b_stb) + int'(mul_z_ack) + int'(wb_valid);
      chk("onehot_handshake", 32'(n), exp_halt ? 32'd0 : 32'd1);
      chk("err_timeout", 32'(err_timeout), 32'(exp_err));
      if (mul_a_stb) chk("mul_a", mul_a, exp_a);
      if (mul_b_stb) chk("mul_b", mul_b, exp_b);
      if (wb_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL wb_unexpected: got wb_valid=1 rd=%0d data=%h, expected no writeback", wb_rd, wb_data);
        end else begin
          chk("wb_rd", 32'(wb_rd), 32'(exp_q[0].rd));
          chk("wb_data", wb_data, exp_q[0].data);
          chk("wb_fflags", 32'(fflags), 32'(exp_q[0].fl));
        end
      end
    end
  end

  always @(posedge clk) begin
    if (!reset && wb_valid && wb_ready) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      wb_seen++;
    end
  end

  // zdly: cycles into WAIT_Z when the product strobes (0 = never, exercise the watchdog).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] z, input int zdly, input int hold, input bit clr_cap);
    wb_t e;
    logic [4:0] nf;
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_a = a; req_b = b; req_rd = rd;
    exp_a = a; exp_b = b;
    @(negedge clk);
    req_valid = 1'b0;
    chk("a_stb_on", 32'(mul_a_stb), 32'd1);
    @(negedge clk); mul_a_ack = 1'b1;
    @(negedge clk); mul_a_ack = 1'b0;
    chk("a_stb_off", 32'(mul_a_stb), 32'd0);
    chk("b_stb_on", 32'(mul_b_stb), 32'd1);
    @(negedge clk); mul_b_ack = 1'b1;
    @(negedge clk); mul_b_ack = 1'b0;
    if (zdly == 0) begin
      for (int k = 1; k <= T + 1; k++) begin
        if (k > 1) @(negedge clk);
        if (k <= T) chk("z_ack_wait", 32'(mul_z_ack), 32'd1);
        else begin
          exp_err = 1'b1; exp_halt = 1'b1;
          chk("timeout_edge", 32'(err_timeout), 32'd1);
        end
      end
      req_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        chk("halt_req_ready", 32'(req_ready), 32'd0);
      end
      req_valid = 1'b0;
      return;
    end
    for (int k = 1; k <= zdly; k++) begin
      if (k > 1) @(negedge clk);
      chk("z_ack_wait", 32'(mul_z_ack), 32'd1);
      if (k == zdly) begin
        mul_z_stb = 1'b1; mul_z = z; fflags_clr = clr_cap;
        nf = model_flags(a, b, z);
        mflags = clr_cap ? nf : (mflags | nf);
        e.rd = rd; e.data = z; e.fl = mflags;
        exp_q.push_back(e);
      end
    end
    @(negedge clk);
    mul_z_stb = 1'b0; fflags_clr = 1'b0;
    chk("wb_valid_on", 32'(wb_valid), 32'd1);
    for (int k = 0; k < hold; k++) @(negedge clk);
    wb_ready = 1'b1;
    @(negedge clk);
    wb_ready = 1'b0;
    chk("idle_after_wb", 32'(req_ready), 32'd1);
  endtask

  task automatic pulse_clr();
    @(negedge clk); fflags_clr = 1'b1;
    @(negedge clk); fflags_clr = 1'b0;
    mflags = 5'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int seen;
    reset = 1'b1; req_valid = 0; req_a = 0; req_b = 0; req_rd = 0;
    mul_a_ack = 0; mul_b_ack = 0; mul_z = 0; mul_z_stb = 0; wb_ready = 0; fflags_clr = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_strobes", 32'({mul_a_stb, mul_b_stb, mul_z_ack, wb_valid}), 32'd0);
    chk("rst_mul_a", mul_a, 32'd0);
    chk("rst_mul_b", mul_b, 32'd0);
    chk("rst_wb", {wb_data[26:0], wb_rd}, 32'd0);
    chk("rst_wb_hi", 32'(wb_data[31:27]), 32'd0);
    chk("rst_fflags", 32'(fflags), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);

    chk("pin_nv", 32'(model_flags(32'h7F800000, 32'h0, 32'h7FC00000)), 32'h10);
    chk("pin_of", 32'(model_flags(32'h7F000000, 32'h7F000000, 32'h7F800000)), 32'h04);
    chk("pin_uf", 32'(model_flags(32'h00800000, 32'h34000000, 32'h00000001)), 32'h02);
    chk("pin_nan_in", 32'(model_flags(32'h7FC00000, 32'h3F800000, 32'h7FC00000)), 32'h00);

    run_op(32'h40000000, 32'h40400000, 5'd3, 32'h40C00000, 10, 0, 1'b0);
    chk("basic_fflags", 32'(fflags), 32'h00);
    run_op(32'h7F800000, 32'h00000000, 5'd5, 32'h7FC00000, 4, 0, 1'b0);
    chk("nv_fflags", 32'(fflags), 32'h10);
    run_op(32'h3F800000, 32'h3F800000, 5'd6, 32'h3F800000, 3, 0, 1'b0);
    chk("nv_sticky", 32'(fflags), 32'h10);
    pulse_clr();
    chk("clr_fflags", 32'(fflags), 32'h00);
    run_op(32'h7F000000, 32'h7F000000, 5'd7, 32'h7F800000, 5, 0, 1'b0);
    chk("of_fflags", 32'(fflags), 32'h04);
    pulse_clr();
    run_op(32'h00800000, 32'h34000000, 5'd8, 32'h00000001, 2, 0, 1'b0);
    chk("uf_fflags", 32'(fflags), 32'h02);
    run_op(32'h7F800000, 32'h00000000, 5'd1, 32'h7FC00000, 1, 0, 1'b1);
    chk("clr_and_capture", 32'(fflags), 32'h10);
    pulse_clr();

    run_op(32'h3F800000, 32'h40000000, 5'd9, 32'h40000000, 6, 20, 1'b0);
    run_op(32'h40000000, 32'h40000000, 5'd10, 32'h40800000, T, 0, 1'b0);
    chk("last_cycle_no_err", 32'(err_timeout), 32'd0);
    chk("wb_count", 32'(wb_seen), 32'd8);

    // Abort in SEND_B: no writeback may ever follow.
    seen = wb_seen;
    @(negedge clk);
    req_valid = 1'b1; req_a = 32'h40000000; req_b = 32'h40000000; req_rd = 5'd11;
    exp_a = req_a; exp_b = req_b;
    @(negedge clk); req_valid = 1'b0; mul_a_ack = 1'b1;
    @(negedge clk); mul_a_ack = 1'b0;
    chk("abort_b_stb", 32'(mul_b_stb), 32'd1);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("abort_strobes", 32'({mul_a_stb, mul_b_stb, mul_z_ack, wb_valid}), 32'd0);
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    repeat (30) @(negedge clk);
    chk("abort_no_wb", 32'(wb_seen), 32'(seen));

    run_op(32'h40000000, 32'h40400000, 5'd12, 32'h0, 0, 0, 1'b0);
    reset = 1'b1; exp_err = 1'b0; exp_halt = 1'b0;
    @(negedge clk); reset = 1'b0;
    chk("post_halt_err", 32'(err_timeout), 32'd0);
    chk("post_halt_ready", 32'(req_ready), 32'd1);
    run_op(32'h3F800000, 32'h3F800000, 5'd2, 32'h3F800000, 3, 0, 1'b0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
